// File: rtl/subtrator_serial_4bits_pkg.sv
// rtl/subtrator_serial_4bits_pkg.sv - shared width and state encoding for the serial subtractor
package subtrator_serial_4bits_pkg;

    // Default operand width, shared with the adder exercises
    localparam int N = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/subtrator_completo.sv
// rtl/subtrator_completo.sv - one-bit full subtractor cell
module subtrator_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow-out of a - b - bin
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/subtrator_serial_4bits.sv
// rtl/subtrator_serial_4bits.sv - bit-serial A - B, LSB first, with start/done handshake
module subtrator_serial_4bits #(
    parameter int N = subtrator_serial_4bits_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N:0]   R,
    output logic         busy,
    output logic         done
);

    import subtrator_serial_4bits_pkg::*;

    localparam int CW = $clog2(N + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  res;
    logic          bw;
    logic          d;
    logic          bw_next;
    logic          accept;
    logic          last_bit;

    // Single subtractor cell working on the current LSBs and the carried borrow
    subtrator_completo u_cell (
        .a    (ra[0]),
        .b    (rb[0]),
        .bin  (bw),
        .d    (d),
        .bout (bw_next)
    );

    // A new operation is taken in IDLE, or in DONE for back-to-back use
    always_comb begin
        accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
        last_bit = (state == ST_SHIFT) && (count == CW'(N - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    // Operand/result shift registers, borrow, bit counter and the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            bw    <= 1'b0;
            count <= '0;
            R     <= '0;
        end else if (accept) begin
            ra    <= A;
            rb    <= B;
            bw    <= 1'b0;
            count <= '0;
        end else if (state == ST_SHIFT) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            res   <= {d, res[N-1:1]};
            bw    <= bw_next;
            count <= count + 1'b1;
            // The final bit completes the difference; capture it with the last borrow
            if (last_bit) begin
                R <= {bw_next, d, res[N-1:1]};
            end
        end
    end

endmodule
